hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter DEPTH, default 2: number of in-flight writer stages tracked after ID (EX, MEM, ...); legal range 1..4.
REQ-002 Parameter LOAD_LAT, default 2: load result is unforwardable while its entry index is < LOAD_LAT.
REQ-003 Parameter FWD_EN, default 1: 1 = forward ALU results and stall only on load-use; 0 = stall on any RAW.
REQ-004 Parameter BRANCH_PENALTY, default 2: stall cycles after a beq/bne issues; range 0..15.
REQ-005 Parameter JUMP_PENALTY, default 1: stall cycles after a j/jal/jr issues; range 0..15.
REQ-006 clk  input  1  single clock, all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 flush_i  input  1  synchronous pipeline flush.
REQ-009 id_valid_i  input  1  instruction present in ID.
REQ-010 id_instr_i  input  32  ID instruction: rs = [25:21], rt = [20:16], opcode = [31:26], funct = [5:0].
REQ-011 id_dst_i / id_regwrite_i / id_memtoreg_i  input  5/1/1  decoded destination and write controls of the ID instruction.
REQ-012 stall_o  output  1  hold PC and IF/ID.
REQ-013 bubble_o  output  1  insert NOP into ID/EX.
REQ-014 fwd_rs_o / fwd_rt_o  output  3 each  operand source: 0 = register file, k+1 = scoreboard entry k.
REQ-015 ctrl_busy_o  output  1  FSM is in CTRL.

Function
REQ-016 Scoreboard sb[0..DEPTH-1] holds {dst, regwrite, memtoreg}; sb[0] is the youngest entry (EX).
REQ-017 Issue = id_valid_i && !stall_o && !flush_i.
REQ-018 Each cycle, sb[k] <= sb[k-1] for k >= 1; sb[0] <= ID controls on issue, else all-zero bubble.
REQ-019 Match on operand r: youngest k with sb[k].regwrite && sb[k].dst == r && r != 0; register 0 never matches.
REQ-020 FWD_EN = 0: data_stall = any rs/rt match; fwd_* = 0.
REQ-021 FWD_EN = 1: data_stall = matched entry has memtoreg && k < LOAD_LAT; otherwise fwd = k+1 when matched, else 0.
REQ-022 rt is checked for every opcode; no per-opcode masking.
REQ-023 FSM states RUN and CTRL; 4-bit counter cnt.
REQ-024 RUN -> CTRL: on issue of beq/bne (opcode 000100/000101) with BRANCH_PENALTY > 0, cnt <= BRANCH_PENALTY-1.
REQ-025 RUN -> CTRL: on issue of j/jal (000010/000011) or jr (opcode 0, funct 001000) with JUMP_PENALTY > 0, cnt <= JUMP_PENALTY-1.
REQ-026 In CTRL: cnt decrements each cycle; cnt == 0 -> RUN.
REQ-027 CTRL lasts exactly PENALTY cycles.
REQ-028 Outputs: stall_o = bubble_o = (state == CTRL) || (id_valid_i && data_stall); all outputs are combinational from state and inputs.
REQ-029 Control instruction under data hazard: data stall first; penalty starts only on the cycle it issues.
REQ-030 Priority: flush_i > CTRL > data hazard.
REQ-031 flush_i: next state RUN, cnt = 0, all sb entries = bubble; stall_o = 0 in the flush cycle.
REQ-032 id_valid_i = 0: no data stall, bubble shifted in, FSM still counts.

Reset
REQ-033 rst_n low: state = RUN, cnt = 0, all sb entries cleared, immediately and asynchronously.
REQ-034 After reset, stall_o = bubble_o = 0 and fwd_* = 0 until the first issue.
REQ-035 Reset mid-CTRL or mid-stall aborts the operation; the pipeline restarts with no residual stall.

Structure
REQ-036 Shared package/include holds: opcode/funct constants (BEQ, BNE, J, JAL, JR), FWD_RF = 0, and the scoreboard entry field widths.
REQ-037 One sub-module, hazard_match: combinational youngest-match finder for one operand against the scoreboard, instantiated for rs and rt.

Verification
REQ-038 Verify: add $3 issues, next instr uses rs = $3, FWD_EN = 1 -> fwd_rs_o = 1, no stall; following cycle -> fwd_rs_o = 2.
REQ-039 Verify: lw $5 issues, next instr uses rt = $5, LOAD_LAT = 2 -> stall_o = bubble_o = 1 for 2 cycles, then fwd_rt_o = 0, issue.
REQ-040 Verify: beq issues with BRANCH_PENALTY = 2 -> ctrl_busy_o = 1 and stall_o = 1 exactly 2 cycles, then RUN.
REQ-041 Verify: instr writes $0, consumer reads $0 -> no stall, fwd = 0; FWD_EN = 0 with consumer of $7 after writer of $7 -> stall for DEPTH cycles.
REQ-042 Verify: flush_i in the 1st CTRL cycle -> stall_o = 0 that cycle, sb empty next cycle; rst_n low mid-load-stall -> outputs 0 immediately.
REQ-043 Verify: jr with JUMP_PENALTY = 0 -> no stall; bne waiting on a load hazard -> 2 data-stall cycles, then 2 CTRL cycles.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
// Opcodes, forwarding encodings and scoreboard entry layout.
package hazard_scoreboard_pkg;

  localparam int SB_DST_W = 5;
  localparam int SB_IDX_W = 2;
  localparam int FWD_W    = 3;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR      = 6'b001000;

  localparam logic [FWD_W-1:0] FWD_RF = '0;

  typedef struct packed {
    logic [SB_DST_W-1:0] dst;
    logic                regwrite;
    logic                memtoreg;
  } sb_entry_t;

  typedef enum logic {
    ST_RUN,
    ST_CTRL
  } state_t;

  function automatic logic [FWD_W-1:0] fwd_sel(
    input logic                hit,
    input logic [SB_IDX_W-1:0] idx
  );
    return hit ? (FWD_W'(idx) + FWD_W'(1)) : FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Youngest-match finder for one source operand.
// Register 0 never matches.
import hazard_scoreboard_pkg::*;

module hazard_match #(
  parameter int DEPTH = 2
) (
  input  logic [SB_DST_W-1:0] reg_i,
  input  sb_entry_t           sb_i [DEPTH],
  output logic                hit_o,
  output logic [SB_IDX_W-1:0] idx_o,
  output logic                load_o
);

  // scan oldest to youngest so the youngest hit wins
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    load_o = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (sb_i[k].regwrite &&
          sb_i[k].dst == reg_i &&
          reg_i != '0) begin
        hit_o  = 1'b1;
        idx_o  = SB_IDX_W'(k);
        load_o = sb_i[k].memtoreg;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: RAW scoreboard, forwarding select
// and branch/jump penalty FSM.
import hazard_scoreboard_pkg::*;

module hazard_scoreboard #(
  parameter int DEPTH          = 2,
  parameter int LOAD_LAT       = 2,
  parameter int FWD_EN         = 1,
  parameter int BRANCH_PENALTY = 2,
  parameter int JUMP_PENALTY   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                id_valid_i,
  input  logic [31:0]         id_instr_i,
  input  logic [SB_DST_W-1:0] id_dst_i,
  input  logic                id_regwrite_i,
  input  logic                id_memtoreg_i,
  output logic                stall_o,
  output logic                bubble_o,
  output logic [FWD_W-1:0]    fwd_rs_o,
  output logic [FWD_W-1:0]    fwd_rt_o,
  output logic                ctrl_busy_o
);

  sb_entry_t sb_q [DEPTH];
  sb_entry_t sb_d [DEPTH];

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [5:0] op, funct;
  logic       is_br, is_jmp;
  logic       issue, data_stall, ctrl;

  logic                rs_hit, rt_hit;
  logic                rs_load, rt_load;
  logic [SB_IDX_W-1:0] rs_idx, rt_idx;
  logic                rs_lstall, rt_lstall;

  logic unused_instr;
  assign unused_instr = ^id_instr_i[15:6];

  assign op    = id_instr_i[31:26];
  assign funct = id_instr_i[5:0];

  assign is_br  = (op == OP_BEQ) || (op == OP_BNE);
  assign is_jmp = (op == OP_J) || (op == OP_JAL) ||
                  (op == OP_SPECIAL && funct == FN_JR);

  hazard_match #(.DEPTH(DEPTH)) u_match_rs (
    .reg_i  (id_instr_i[25:21]),
    .sb_i   (sb_q),
    .hit_o  (rs_hit),
    .idx_o  (rs_idx),
    .load_o (rs_load)
  );

  hazard_match #(.DEPTH(DEPTH)) u_match_rt (
    .reg_i  (id_instr_i[20:16]),
    .sb_i   (sb_q),
    .hit_o  (rt_hit),
    .idx_o  (rt_idx),
    .load_o (rt_load)
  );

  // load results still in flight cannot be forwarded yet
  always_comb begin
    rs_lstall = rs_hit && rs_load &&
                (int'(rs_idx) < LOAD_LAT);
    rt_lstall = rt_hit && rt_load &&
                (int'(rt_idx) < LOAD_LAT);
  end

  // hazard decision and operand source select
  always_comb begin
    data_stall = 1'b0;
    fwd_rs_o   = FWD_RF;
    fwd_rt_o   = FWD_RF;
    if (FWD_EN != 0) begin
      data_stall = rs_lstall || rt_lstall;
      if (!rs_lstall) fwd_rs_o = fwd_sel(rs_hit, rs_idx);
      if (!rt_lstall) fwd_rt_o = fwd_sel(rt_hit, rt_idx);
    end else begin
      data_stall = rs_hit || rt_hit;
    end
  end

  assign ctrl        = (state_q == ST_CTRL);
  assign ctrl_busy_o = ctrl;
  assign stall_o     = !flush_i &&
                       (ctrl || (id_valid_i && data_stall));
  assign bubble_o    = stall_o;
  assign issue       = id_valid_i && !stall_o && !flush_i;

  // shift the scoreboard; new entry or bubble at the young end
  always_comb begin
    sb_d[0] = '0;
    if (issue) begin
      sb_d[0].dst      = id_dst_i;
      sb_d[0].regwrite = id_regwrite_i;
      sb_d[0].memtoreg = id_memtoreg_i;
    end
    for (int k = 1; k < DEPTH; k++) begin
      sb_d[k] = flush_i ? '0 : sb_q[k-1];
    end
  end

  // scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) sb_q[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) sb_q[k] <= sb_d[k];
    end
  end

  // penalty FSM next state; flush overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (issue && is_br && BRANCH_PENALTY > 0) begin
          state_d = ST_CTRL;
          cnt_d   = 4'(BRANCH_PENALTY - 1);
        end else if (issue && is_jmp &&
                     JUMP_PENALTY > 0) begin
          state_d = ST_CTRL;
          cnt_d   = 4'(JUMP_PENALTY - 1);
        end
      end
      ST_CTRL: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    endcase
    if (flush_i) begin
      state_d = ST_RUN;
      cnt_d   = 4'd0;
    end
  end

  // penalty FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
